// File: rtl/i2s_frame_clk_gen_pkg.sv
// i2s_pkg: FSM states, WS framing modes and counter-width helper shared by the I2S clock generator.
package i2s_pkg;
  typedef enum logic {I2S_IDLE, I2S_RUN} i2s_state_e;
  localparam logic I2S_WS_STD = 1'b0;
  localparam logic I2S_WS_PULSE = 1'b1;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/i2s_frame_clk_gen_if.sv
// i2s_frame_clk_gen_if: run control in, clocks/strobes/position out; I2S_FRAME_CLK_GEN_MCLK_EN adds mclk.
interface i2s_frame_clk_gen_if import i2s_pkg::*; #(
  parameter int SLOT_BITS = 32,
  parameter int CHANNELS = 2,
  parameter int DIV_W = 8
) ();
  logic en;
  logic [DIV_W-1:0] half_div;
  logic pulse_mode;
  logic bclk, ws, bclk_rise, bclk_fall, frame_start, active;
  logic [cnt_w(CHANNELS)-1:0] slot;
  logic [cnt_w(SLOT_BITS)-1:0] bit_idx;
`ifdef I2S_FRAME_CLK_GEN_MCLK_EN
  logic mclk;
  modport master (output en, half_div, pulse_mode,
                  input bclk, ws, bclk_rise, bclk_fall, frame_start, slot, bit_idx, active, mclk);
  modport slave (input en, half_div, pulse_mode,
                 output bclk, ws, bclk_rise, bclk_fall, frame_start, slot, bit_idx, active, mclk);
`else
  modport master (output en, half_div, pulse_mode,
                  input bclk, ws, bclk_rise, bclk_fall, frame_start, slot, bit_idx, active);
  modport slave (input en, half_div, pulse_mode,
                 output bclk, ws, bclk_rise, bclk_fall, frame_start, slot, bit_idx, active);
`endif
endinterface

// File: rtl/i2s_frame_clk_gen_edge_div.sv
// i2s_edge_div: BCLK half-period counter with latched divisor; stop_i forces bclk low without a fall strobe.
module i2s_edge_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             run_i,
  input  logic             load_i,
  input  logic             stop_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o,
  output logic             bclk_o,
  output logic             rise_o,
  output logic             fall_o
);
  logic [DIV_W-1:0] n_q, n_d, cnt_q, cnt_d;
  logic bclk_q, bclk_d, rise_q, rise_d, fall_q, fall_d;
  assign tick_o = run_i && (cnt_q == n_q);
  always_comb begin
    n_d = load_i ? div_i : n_q;
    cnt_d = (!run_i || tick_o) ? '0 : cnt_q + 1'b1;
    bclk_d = run_i && (tick_o ? !bclk_q : bclk_q);
    rise_d = tick_o && !bclk_q;
    fall_d = tick_o && bclk_q && !stop_i;
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      n_q <= '0;
      cnt_q <= '0;
      bclk_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      n_q <= n_d;
      cnt_q <= cnt_d;
      bclk_q <= bclk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign bclk_o = bclk_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/i2s_frame_clk_gen.sv
// i2s_frame_clk_gen: I2S/TDM BCLK/WS generator with slot/bit position tracking.
// I2S_FRAME_CLK_GEN_MCLK_EN adds a free-running mclk of period MCLK_DIV.
module i2s_frame_clk_gen import i2s_pkg::*; #(
  parameter int SLOT_BITS = 32,
  parameter int CHANNELS = 2,
  parameter int DIV_W = 8
`ifdef I2S_FRAME_CLK_GEN_MCLK_EN
  , parameter int MCLK_DIV = 4
`endif
) (
  input logic clk_in,
  input logic reset,
  i2s_frame_clk_gen_if.slave bus
);
  localparam int SW = cnt_w(CHANNELS);
  localparam int BW = cnt_w(SLOT_BITS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);
  localparam logic [SW-1:0] WS_SLOT = SW'(CHANNELS / 2 - 1);
  localparam logic [BW-1:0] MSB = BW'(SLOT_BITS - 1);
  i2s_state_e state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [BW-1:0] bit_q, bit_d;
  logic pm_q, pm_d, ws_q, ws_d, fs_q, fs_d, act_q, act_d;
  logic run, tick, bclk, fall_now, boundary, stop, load, hit_hi, hit_lo;
  i2s_edge_div #(.DIV_W(DIV_W)) u_div (
    .clk_in(clk_in), .reset(reset), .run_i(run), .load_i(load), .stop_i(stop),
    .div_i(bus.half_div), .tick_o(tick), .bclk_o(bclk), .rise_o(bus.bclk_rise), .fall_o(bus.bclk_fall)
  );
  always_comb begin
    run = state_q == I2S_RUN;
    fall_now = tick && bclk;
    boundary = fall_now && slot_q == LAST_SLOT && bit_q == '0;
    stop = boundary && !bus.en;
    load = (state_q == I2S_IDLE && bus.en) || boundary;
    state_d = (state_q == I2S_IDLE) ? (bus.en ? I2S_RUN : I2S_IDLE) : (stop ? I2S_IDLE : I2S_RUN);
    act_d = state_q == I2S_RUN || state_d == I2S_RUN;
    pm_d = load ? bus.pulse_mode : pm_q;
    slot_d = slot_q;
    bit_d = bit_q;
    if (!run) begin
      slot_d = LAST_SLOT;
      bit_d = '0;
    end else if (fall_now && !stop) begin
      bit_d = (bit_q == '0) ? MSB : bit_q - 1'b1;
      slot_d = (bit_q != '0) ? slot_q : (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
    end
    // WS leads the slot boundary by one bit, so it is decided from the position being entered
    hit_hi = bit_d == '0 && slot_d == WS_SLOT;
    hit_lo = bit_d == '0 && slot_d == LAST_SLOT;
    ws_d = (!run || stop) ? 1'b0 : !fall_now ? ws_q :
           (pm_q == I2S_WS_PULSE) ? hit_lo : (hit_hi || (ws_q && !hit_lo));
    fs_d = boundary && bus.en;
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= I2S_IDLE;
      slot_q <= '0;
      bit_q <= '0;
      pm_q <= I2S_WS_STD;
      ws_q <= 1'b0;
      fs_q <= 1'b0;
      act_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      bit_q <= bit_d;
      pm_q <= pm_d;
      ws_q <= ws_d;
      fs_q <= fs_d;
      act_q <= act_d;
    end
  end
  assign bus.bclk = bclk;
  assign bus.ws = ws_q;
  assign bus.frame_start = fs_q;
  assign bus.slot = slot_q;
  assign bus.bit_idx = bit_q;
  assign bus.active = act_q;
`ifdef I2S_FRAME_CLK_GEN_MCLK_EN
  localparam int MW = cnt_w(MCLK_DIV);
  localparam logic [MW-1:0] MC_TOP = MW'(MCLK_DIV / 2 - 1);
  logic [MW-1:0] mc_q, mc_d;
  logic mclk_q, mclk_d;
  always_comb begin
    mc_d = (mc_q == MC_TOP) ? '0 : mc_q + 1'b1;
    mclk_d = mclk_q ^ (mc_q == MC_TOP);
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      mc_q <= '0;
      mclk_q <= 1'b0;
    end else begin
      mc_q <= mc_d;
      mclk_q <= mclk_d;
    end
  end
  assign bus.mclk = mclk_q;
`endif
endmodule
